axi_rr_arbiter2: RTL and testbench

//  2:1 AXI4 arbiter: two masters (m0 = IFU fetch, m1 = LSU) share one downstream AXI slave port (the crossbar/xbar input).

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/axi_rr_arbiter2_if.sv | 68 ++++++
 rtl/axi_rr_arbiter2_rr_arb2.sv | 42 ++++
 rtl/axi_rr_arbiter2.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_rr_arbiter2.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the 2:1 AXI round-robin arbiter.
// FSM state enums, burst and response encodings.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rr_arbiter2_if.sv
// One AXI4 port (AR, R, AW, W, B channels), parameterised on widths.
// master: the side issuing requests; slave: the side answering them.
interface axi_rr_arbiter2_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic              rlast;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;

    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );

endinterface

// File: rtl/axi_rr_arbiter2_rr_arb2.sv
// Two-way round-robin arbiter with a registered one-hot grant.
// Ports: clock, reset, req[1:0] (sampled only while gnt is empty), advance (release grant), gnt[1:0].
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic [1:0] gnt_q, gnt_d;
    logic       ptr_q, ptr_d;

    always_comb begin
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (advance) begin
            gnt_d = 2'b00;
            // Favour whichever master was not just served.
            ptr_d = gnt_q[0];
        end else if (gnt_q == 2'b00 && req != 2'b00) begin
            if (req[0] && (!ptr_q || !req[1])) begin
                gnt_d = 2'b01;
            end else begin
                gnt_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q <= 2'b00;
            ptr_q <= 1'b0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/axi_rr_arbiter2.sv
// 2:1 AXI4 arbiter: m0 and m1 share slave port s; read and write arbitrate independently.
// Ports: clock, reset (sync, active-high), m0/m1 (slave modports), s (master modport), err_wlast[1:0].
module axi_rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    axi_rr_arbiter2_if.slave  m0,
    axi_rr_arbiter2_if.slave  m1,
    axi_rr_arbiter2_if.master s,
    output logic [1:0]        err_wlast
);

    r_state_t   r_state_q, r_state_d;
    w_state_t   w_state_q, w_state_d;
    logic [1:0] r_gnt, w_gnt;
    logic       r_adv, w_adv;
    logic [7:0] w_len_q, w_len_d;
    logic [7:0] w_cnt_q, w_cnt_d;
    logic       r_sel, w_sel;
    logic       w_mlast;

    assign r_sel = r_gnt[1];
    assign w_sel = w_gnt[1];

    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({m1.arvalid, m0.arvalid} & {2{r_state_q == R_IDLE}}),
        .advance (r_adv),
        .gnt     (r_gnt)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset   (reset),
        .req     ({m1.awvalid, m0.awvalid} & {2{w_state_q == W_IDLE}}),
        .advance (w_adv),
        .gnt     (w_gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_adv     = 1'b0;
        unique case (r_state_q)
            R_IDLE: if (m0.arvalid | m1.arvalid) r_state_d = R_ADDR;
            R_ADDR: if (s.arvalid & s.arready) r_state_d = R_DATA;
            R_DATA: begin
                if (s.rvalid & s.rready & s.rlast) begin
                    r_state_d = R_IDLE;
                    r_adv     = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_adv     = 1'b0;
        unique case (w_state_q)
            W_IDLE: if (m0.awvalid | m1.awvalid) w_state_d = W_ADDR;
            W_ADDR: begin
                if (s.awvalid & s.awready) begin
                    w_state_d = W_DATA;
                    w_len_d   = s.awlen;
                    w_cnt_d   = 8'd0;
                end
            end
            W_DATA: begin
                if (s.wvalid & s.wready) begin
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (s.wlast) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s.bvalid & s.bready) begin
                    w_state_d = W_IDLE;
                    w_adv     = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path mux: driven only in the phase that owns each channel.
    always_comb begin
        s.arvalid  = 1'b0;
        s.araddr   = '0;
        s.arid     = '0;
        s.arlen    = '0;
        s.arsize   = '0;
        s.arburst  = '0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rid     = '0;
        m0.rlast   = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rid     = '0;
        m1.rlast   = 1'b0;
        if (r_state_q == R_ADDR) begin
            if (r_sel) begin
                s.arvalid  = m1.arvalid;
                s.araddr   = m1.araddr;
                s.arid     = m1.arid;
                s.arlen    = m1.arlen;
                s.arsize   = m1.arsize;
                s.arburst  = m1.arburst;
                m1.arready = s.arready;
            end else begin
                s.arvalid  = m0.arvalid;
                s.araddr   = m0.araddr;
                s.arid     = m0.arid;
                s.arlen    = m0.arlen;
                s.arsize   = m0.arsize;
                s.arburst  = m0.arburst;
                m0.arready = s.arready;
            end
        end
        if (r_state_q == R_DATA) begin
            if (r_sel) begin
                m1.rvalid = s.rvalid;
                m1.rdata  = s.rdata;
                m1.rresp  = s.rresp;
                m1.rid    = s.rid;
                m1.rlast  = s.rlast;
                s.rready  = m1.rready;
            end else begin
                m0.rvalid = s.rvalid;
                m0.rdata  = s.rdata;
                m0.rresp  = s.rresp;
                m0.rid    = s.rid;
                m0.rlast  = s.rlast;
                s.rready  = m0.rready;
            end
        end
    end

    // Write path mux; WLAST comes from the beat counter, not the master.
    always_comb begin
        s.awvalid  = 1'b0;
        s.awaddr   = '0;
        s.awid     = '0;
        s.awlen    = '0;
        s.awsize   = '0;
        s.awburst  = '0;
        s.wvalid   = 1'b0;
        s.wdata    = '0;
        s.wstrb    = '0;
        s.wlast    = 1'b0;
        s.bready   = 1'b0;
        m0.awready = 1'b0;
        m1.awready = 1'b0;
        m0.wready  = 1'b0;
        m1.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m0.bresp   = '0;
        m0.bid     = '0;
        m1.bvalid  = 1'b0;
        m1.bresp   = '0;
        m1.bid     = '0;
        err_wlast  = 2'b00;
        w_mlast    = 1'b0;
        if (w_state_q == W_ADDR) begin
            if (w_sel) begin
                s.awvalid  = m1.awvalid;
                s.awaddr   = m1.awaddr;
                s.awid     = m1.awid;
                s.awlen    = m1.awlen;
                s.awsize   = m1.awsize;
                s.awburst  = m1.awburst;
                m1.awready = s.awready;
            end else begin
                s.awvalid  = m0.awvalid;
                s.awaddr   = m0.awaddr;
                s.awid     = m0.awid;
                s.awlen    = m0.awlen;
                s.awsize   = m0.awsize;
                s.awburst  = m0.awburst;
                m0.awready = s.awready;
            end
        end
        if (w_state_q == W_DATA) begin
            s.wlast = (w_cnt_q == w_len_q);
            if (w_sel) begin
                s.wvalid  = m1.wvalid;
                s.wdata   = m1.wdata;
                s.wstrb   = m1.wstrb;
                m1.wready = s.wready;
                w_mlast   = m1.wlast;
            end else begin
                s.wvalid  = m0.wvalid;
                s.wdata   = m0.wdata;
                s.wstrb   = m0.wstrb;
                m0.wready = s.wready;
                w_mlast   = m0.wlast;
            end
            if (s.wvalid && s.wready && (w_mlast != s.wlast)) begin
                err_wlast = w_sel ? 2'b10 : 2'b01;
            end
        end
        if (w_state_q == W_RESP) begin
            if (w_sel) begin
                m1.bvalid = s.bvalid;
                m1.bresp  = s.bresp;
                m1.bid    = s.bid;
                s.bready  = m1.bready;
            end else begin
                m0.bvalid = s.bvalid;
                m0.bresp  = s.bresp;
                m0.bid    = s.bid;
                s.bready  = m0.bready;
            end
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter2.sv
// Directed self-checking bench for axi_rr_arbiter2.
// Drives both masters and a scripted slave; checks routing, fairness, WLAST and reset.
module tb_axi_rr_arbiter2;
    import axi_arb_pkg::*;

    logic       clock;
    logic       reset;
    logic [1:0] err_wlast;
    int         total;
    int         passed;

    axi_rr_arbiter2_if m0_if ();
    axi_rr_arbiter2_if m1_if ();
    axi_rr_arbiter2_if s_if ();

    axi_rr_arbiter2 dut (
        .clock     (clock),
        .reset     (reset),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .err_wlast (err_wlast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic        arv [2];
    logic [31:0] ara [2];
    logic [3:0]  ari [2];
    logic [7:0]  arl [2];
    logic        rr  [2];
    logic        awv [2];
    logic [31:0] awa [2];
    logic [3:0]  awi [2];
    logic [7:0]  awl [2];
    logic        wv  [2];
    logic [63:0] wd  [2];
    logic        wl  [2];
    logic        br  [2];

    assign m0_if.arvalid = arv[0];
    assign m0_if.araddr  = ara[0];
    assign m0_if.arid    = ari[0];
    assign m0_if.arlen   = arl[0];
    assign m0_if.arsize  = 3'd3;
    assign m0_if.arburst = BURST_INCR;
    assign m0_if.rready  = rr[0];
    assign m0_if.awvalid = awv[0];
    assign m0_if.awaddr  = awa[0];
    assign m0_if.awid    = awi[0];
    assign m0_if.awlen   = awl[0];
    assign m0_if.awsize  = 3'd3;
    assign m0_if.awburst = BURST_INCR;
    assign m0_if.wvalid  = wv[0];
    assign m0_if.wdata   = wd[0];
    assign m0_if.wstrb   = 8'hFF;
    assign m0_if.wlast   = wl[0];
    assign m0_if.bready  = br[0];

    assign m1_if.arvalid = arv[1];
    assign m1_if.araddr  = ara[1];
    assign m1_if.arid    = ari[1];
    assign m1_if.arlen   = arl[1];
    assign m1_if.arsize  = 3'd3;
    assign m1_if.arburst = BURST_INCR;
    assign m1_if.rready  = rr[1];
    assign m1_if.awvalid = awv[1];
    assign m1_if.awaddr  = awa[1];
    assign m1_if.awid    = awi[1];
    assign m1_if.awlen   = awl[1];
    assign m1_if.awsize  = 3'd3;
    assign m1_if.awburst = BURST_INCR;
    assign m1_if.wvalid  = wv[1];
    assign m1_if.wdata   = wd[1];
    assign m1_if.wstrb   = 8'hFF;
    assign m1_if.wlast   = wl[1];
    assign m1_if.bready  = br[1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s_vld"}, 64'({s_if.arvalid, s_if.rready, s_if.awvalid,
                                  s_if.wvalid, s_if.wlast, s_if.bready}), 64'd0);
        chk({tag, "_m0"}, 64'({m0_if.arready, m0_if.rvalid, m0_if.awready,
                               m0_if.wready, m0_if.bvalid}), 64'd0);
        chk({tag, "_m1"}, 64'({m1_if.arready, m1_if.rvalid, m1_if.awready,
                               m1_if.wready, m1_if.bvalid}), 64'd0);
        chk({tag, "_data"}, 64'(s_if.araddr) | s_if.wdata | m0_if.rdata | m1_if.rdata, 64'd0);
        chk({tag, "_err"}, 64'(err_wlast), 64'd0);
        chk({tag, "_rst"}, 64'(dut.r_state_q), 64'(R_IDLE));
        chk({tag, "_wst"}, 64'(dut.w_state_q), 64'(W_IDLE));
    endtask

    // abort_at >= 0 raises reset during that beat and returns with rvalid still high.
    task automatic do_read(input int m, input logic [31:0] addr, input int len,
                           input logic [3:0] id, input int gap,
                           input logic [63:0] base, input int abort_at);
        arv[m] = 1'b1;
        ara[m] = addr;
        ari[m] = id;
        arl[m] = 8'(len);
        @(negedge clock);
        chk("ar_idle", 64'(s_if.arvalid), 64'd0);
        step();
        s_if.arready = 1'b1;
        @(negedge clock);
        chk("ar_fwd", 64'(s_if.arvalid), 64'd1);
        chk("ar_addr", 64'(s_if.araddr), 64'(addr));
        chk("ar_len", 64'(s_if.arlen), 64'(len));
        chk("ar_rdy", 64'({m1_if.arready, m0_if.arready}), (m == 1) ? 64'd2 : 64'd1);
        step();
        arv[m] = 1'b0;
        s_if.arready = 1'b0;
        rr[m] = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            chk("r_wait", 64'({m1_if.rvalid, m0_if.rvalid}), 64'd0);
            step();
        end
        for (int b = 0; b <= len; b++) begin
            s_if.rvalid = 1'b1;
            s_if.rdata  = base + 64'(b);
            s_if.rid    = id;
            s_if.rresp  = RESP_OKAY;
            s_if.rlast  = (b == len);
            if (b == abort_at) reset = 1'b1;
            @(negedge clock);
            chk("r_vld", 64'({m1_if.rvalid, m0_if.rvalid}), (m == 1) ? 64'd2 : 64'd1);
            chk("r_data", (m == 1) ? m1_if.rdata : m0_if.rdata, base + 64'(b));
            chk("r_last", 64'((m == 1) ? m1_if.rlast : m0_if.rlast), 64'(b == len));
            chk("r_id", 64'((m == 1) ? m1_if.rid : m0_if.rid), 64'(id));
            chk("r_rdy", 64'(s_if.rready), 64'd1);
            step();
            if (b == abort_at) begin
                reset = 1'b0;
                rr[m] = 1'b0;
                return;
            end
        end
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        rr[m] = 1'b0;
    endtask

    // wl_at: 1-based beat on which the master raises its own wlast.
    task automatic do_write(input int m, input int len, input int wl_at,
                            input logic [3:0] id);
        awv[m] = 1'b1;
        awa[m] = 32'h4000_0000;
        awi[m] = id;
        awl[m] = 8'(len);
        wv[m]  = 1'b1;
        wd[m]  = 64'hC0DE_0000_0000_0000;
        wl[m]  = (wl_at == 1);
        s_if.wready = 1'b1;
        @(negedge clock);
        chk("aw_idle", 64'({s_if.awvalid, s_if.wvalid}), 64'd0);
        chk("w_hold0", 64'({m1_if.wready, m0_if.wready}), 64'd0);
        step();
        s_if.awready = 1'b1;
        @(negedge clock);
        chk("aw_fwd", 64'(s_if.awvalid), 64'd1);
        chk("aw_len", 64'(s_if.awlen), 64'(len));
        chk("aw_id", 64'(s_if.awid), 64'(id));
        chk("aw_rdy", 64'({m1_if.awready, m0_if.awready}), (m == 1) ? 64'd2 : 64'd1);
        chk("w_hold1", 64'({m1_if.wready, m0_if.wready}), 64'd0);
        step();
        awv[m] = 1'b0;
        s_if.awready = 1'b0;
        for (int b = 0; b <= len; b++) begin
            logic mis;
            wd[m] = 64'hC0DE_0000_0000_0000 + 64'(b);
            wl[m] = ((b + 1) == wl_at);
            mis   = (((b + 1) == wl_at) != (b == len));
            @(negedge clock);
            chk("w_vld", 64'(s_if.wvalid), 64'd1);
            chk("w_data", s_if.wdata, 64'hC0DE_0000_0000_0000 + 64'(b));
            chk("w_slast", 64'(s_if.wlast), 64'(b == len));
            chk("w_err", 64'(err_wlast), mis ? ((m == 1) ? 64'd2 : 64'd1) : 64'd0);
            step();
        end
        wv[m] = 1'b0;
        wl[m] = 1'b0;
        s_if.bvalid = 1'b1;
        s_if.bresp  = RESP_OKAY;
        s_if.bid    = id;
        br[m] = 1'b1;
        @(negedge clock);
        chk("b_vld", 64'({m1_if.bvalid, m0_if.bvalid}), (m == 1) ? 64'd2 : 64'd1);
        chk("b_resp", 64'((m == 1) ? m1_if.bresp : m0_if.bresp), 64'(RESP_OKAY));
        chk("b_id", 64'((m == 1) ? m1_if.bid : m0_if.bid), 64'(id));
        chk("b_rdy", 64'(s_if.bready), 64'd1);
        step();
        s_if.bvalid = 1'b0;
        s_if.bid    = '0;
        br[m] = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            arv[i] = 1'b0; ara[i] = '0; ari[i] = '0; arl[i] = '0; rr[i] = 1'b0;
            awv[i] = 1'b0; awa[i] = '0; awi[i] = '0; awl[i] = '0;
            wv[i]  = 1'b0; wd[i]  = '0; wl[i]  = 1'b0; br[i] = 1'b0;
        end
        s_if.arready = 1'b0;
        s_if.rvalid  = 1'b0;
        s_if.rdata   = '0;
        s_if.rresp   = '0;
        s_if.rid     = '0;
        s_if.rlast   = 1'b0;
        s_if.awready = 1'b0;
        s_if.wready  = 1'b0;
        s_if.bvalid  = 1'b0;
        s_if.bresp   = '0;
        s_if.bid     = '0;
        do_reset();
        @(negedge clock);
        chk_idle("reset");
        step();

        // single-beat m0 read, data after 3 idle cycles
        do_read(0, 32'h8000_0000, 0, 4'd3, 3, 64'h1122_3344_5566_7788, -1);
        @(negedge clock);
        chk_idle("rd1_done");
        step();

        // three back-to-back contended reads: m0, m1, m0
        do_reset();
        arv[0] = 1'b1; ara[0] = 32'h100; arl[0] = 8'd0;
        arv[1] = 1'b1; ara[1] = 32'h200; arl[1] = 8'd0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        s_if.arready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic g;
            g = (k == 1);
            @(negedge clock);
            chk("rr_gap", 64'(s_if.arvalid), 64'd0);
            step();
            @(negedge clock);
            chk("rr_addr", 64'(s_if.araddr), g ? 64'h200 : 64'h100);
            chk("rr_rdy", 64'({m1_if.arready, m0_if.arready}), g ? 64'd2 : 64'd1);
            step();
            s_if.rvalid = 1'b1;
            s_if.rlast  = 1'b1;
            s_if.rdata  = 64'(k);
            @(negedge clock);
            chk("rr_rvld", 64'({m1_if.rvalid, m0_if.rvalid}), g ? 64'd2 : 64'd1);
            step();
            s_if.rvalid = 1'b0;
            s_if.rlast  = 1'b0;
            if (k == 2) begin
                arv[0] = 1'b0;
                arv[1] = 1'b0;
            end
        end
        rr[0] = 1'b0; rr[1] = 1'b0;
        s_if.arready = 1'b0;
        step();

        // m1 write len=3, correct wlast
        do_write(1, 3, 4, 4'd5);
        // m1 write len=1, wlast early on beat 1
        do_write(1, 1, 1, 4'd9);
        @(negedge clock);
        chk_idle("wr_done");
        step();

        // concurrent m0 read burst and m1 write
        fork
            do_read(0, 32'h9000_0000, 7, 4'd2, 1, 64'hA5A5_0000_0000_0000, -1);
            do_write(1, 0, 1, 4'd7);
        join
        step();

        // reset during beat 3 of 8, then a fresh m1 request
        do_read(0, 32'hA000_0000, 7, 4'd1, 0, 64'h5A5A_0000_0000_0000, 2);
        @(negedge clock);
        chk_idle("mid_rst");
        step();
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        do_read(1, 32'hB000_0000, 1, 4'd6, 1, 64'h7700_0000_0000_0000, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
